// File: rtl/mux_scan_ctrl.sv
// Serializer that walks the select of an external 8:1 mux across a held byte, one beat per transfer.
// Optional build macro MUX_SCAN_PARITY_EN appends an even-parity beat after the eight data beats.
module mux_scan_ctrl #(
    parameter int SCAN_DOWN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    input  logic       mux_y,
    output logic       ser_valid,
    output logic       ser_bit,
    output logic       ser_last,
    input  logic       ser_ready
);

    localparam logic [2:0] FIRST_SEL = (SCAN_DOWN != 0) ? 3'd7 : 3'd0;
`ifdef MUX_SCAN_PARITY_EN
    localparam logic [3:0] LAST_BEAT = 4'd8;
`else
    localparam logic [3:0] LAST_BEAT = 4'd7;
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] beat_cnt;
    logic       load;
    logic       xfer;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity_q;
`endif

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ser_valid  = (state == SHIFT);
        ser_last   = (state == SHIFT) && (beat_cnt == LAST_BEAT);
        in_ready   = (state == IDLE) || (ser_last && ser_ready);
        load       = in_valid && in_ready;
        xfer       = ser_valid && ser_ready;
        ser_bit    = mux_y;
`ifdef MUX_SCAN_PARITY_EN
        if (beat_cnt == 4'd8) begin
            ser_bit = parity_q;
        end
`endif
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (xfer && ser_last) state_next = load ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_i    <= 8'h00;
            mux_s    <= FIRST_SEL;
            beat_cnt <= 4'd0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (load) begin
            mux_i    <= in_data;
            mux_s    <= FIRST_SEL;
            beat_cnt <= 4'd0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= ^in_data;
`endif
        end else if (xfer && !ser_last) begin
            beat_cnt <= beat_cnt + 4'd1;
            // The parity beat reuses the final select, so stop stepping after the eighth data beat.
            if (beat_cnt != 4'd7) begin
                mux_s <= (SCAN_DOWN != 0) ? mux_s - 3'd1 : mux_s + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: an up-scan and a down-scan instance, each driving a modelled 8:1 mux.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid0 = 1'b0;
    logic [7:0] in_data0 = 8'h00;
    logic       in_ready0;
    logic [7:0] mux_i0;
    logic [2:0] mux_s0;
    logic       mux_y0;
    logic       ser_valid0, ser_bit0, ser_last0;
    logic       ser_ready0 = 1'b1;

    logic       in_valid1 = 1'b0;
    logic [7:0] in_data1 = 8'h00;
    logic       in_ready1;
    logic [7:0] mux_i1;
    logic [2:0] mux_s1;
    logic       mux_y1;
    logic       ser_valid1, ser_bit1, ser_last1;
    logic       ser_ready1 = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mux_y0 = mux_i0[mux_s0];
    assign mux_y1 = mux_i1[mux_s1];

    mux_scan_ctrl #(.SCAN_DOWN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
        .mux_i(mux_i0), .mux_s(mux_s0), .mux_y(mux_y0), .ser_valid(ser_valid0),
        .ser_bit(ser_bit0), .ser_last(ser_last0), .ser_ready(ser_ready0)
    );

    mux_scan_ctrl #(.SCAN_DOWN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .mux_i(mux_i1), .mux_s(mux_s1), .mux_y(mux_y1), .ser_valid(ser_valid1),
        .ser_bit(ser_bit1), .ser_last(ser_last1), .ser_ready(ser_ready1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one word to the up-scan instance; returns at the negedge where beat 1 is visible.
    task automatic load0(input logic [7:0] d);
        check("load in_ready", 32'(in_ready0), 32'd1);
        in_valid0 = 1'b1;
        in_data0  = d;
        @(negedge clk);
        in_valid0 = 1'b0;
    endtask

    // Check nbeats beats of word d on the up-scan instance, optionally stalling and chaining a next word.
    task automatic stream0(input logic [7:0] d, input int nbeats, input bit chain, input logic [7:0] nd,
                           input int stall_at, input int stall_len);
        logic [2:0] exp_s;
        logic       exp_b;
        for (int i = 0; i < nbeats; i++) begin
            in_valid0 = 1'b0;
            exp_s = (i < 8) ? 3'(i) : 3'd7;
            exp_b = (i < 8) ? d[i] : ^d;
            if (i == stall_at) begin
                ser_ready0 = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    in_valid0 = 1'b1;
                    in_data0  = 8'h55;
                    #1;
                    check($sformatf("stall%0d valid", k), 32'(ser_valid0), 32'd1);
                    check($sformatf("stall%0d sel", k), 32'(mux_s0), 32'(exp_s));
                    check($sformatf("stall%0d bit", k), 32'(ser_bit0), 32'(exp_b));
                    check($sformatf("stall%0d in_ready", k), 32'(in_ready0), 32'd0);
                    check($sformatf("stall%0d mux_i", k), 32'(mux_i0), 32'(d));
                    @(negedge clk);
                end
                in_valid0  = 1'b0;
                ser_ready0 = 1'b1;
                #1;
            end
            check($sformatf("w%0h b%0d valid", d, i), 32'(ser_valid0), 32'd1);
            check($sformatf("w%0h b%0d sel", d, i), 32'(mux_s0), 32'(exp_s));
            check($sformatf("w%0h b%0d bit", d, i), 32'(ser_bit0), 32'(exp_b));
            check($sformatf("w%0h b%0d last", d, i), 32'(ser_last0), 32'(i == NB - 1));
            check($sformatf("w%0h b%0d in_ready", d, i), 32'(in_ready0), 32'(i == NB - 1));
            if (chain && i == NB - 1) begin
                in_valid0 = 1'b1;
                in_data0  = nd;
            end
            @(negedge clk);
        end
        in_valid0 = 1'b0;
    endtask

    task automatic check_idle0(input string tag, input logic [2:0] exp_s);
        check({tag, " valid"}, 32'(ser_valid0), 32'd0);
        check({tag, " last"}, 32'(ser_last0), 32'd0);
        check({tag, " in_ready"}, 32'(in_ready0), 32'd1);
        check({tag, " sel"}, 32'(mux_s0), 32'(exp_s));
    endtask

    initial begin
        logic [7:0] d1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle0("reset", 3'd0);
        check("reset mux_i", 32'(mux_i0), 32'h00);
        check("reset sel down", 32'(mux_s1), 32'd7);
        check("reset in_ready down", 32'(in_ready1), 32'd1);

        // Single word, no backpressure.
        load0(8'hA5);
        stream0(8'hA5, NB, 1'b0, 8'h00, -1, 0);
        check_idle0("after a5", 3'd7);
        check("after a5 mux_i", 32'(mux_i0), 32'hA5);

        // Back-to-back words with no gap between them.
        load0(8'h0F);
        stream0(8'h0F, NB, 1'b1, 8'hF0, -1, 0);
        stream0(8'hF0, NB, 1'b0, 8'h00, -1, 0);
        check_idle0("after f0", 3'd7);

        // Five-cycle stall on beat 3, with a word offered during the stall.
        load0(8'h81);
        stream0(8'h81, NB, 1'b0, 8'h00, 2, 5);
        check_idle0("after 81", 3'd7);

        // Down-scan instance.
        d1 = 8'h01;
        in_valid1 = 1'b1;
        in_data1  = d1;
        @(negedge clk);
        in_valid1 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check($sformatf("dn b%0d valid", i), 32'(ser_valid1), 32'd1);
            check($sformatf("dn b%0d sel", i), 32'(mux_s1), (i < 8) ? 32'(7 - i) : 32'd0);
            check($sformatf("dn b%0d bit", i), 32'(ser_bit1), (i < 8) ? 32'(d1[7 - i]) : 32'(^d1));
            check($sformatf("dn b%0d last", i), 32'(ser_last1), 32'(i == NB - 1));
            @(negedge clk);
        end
        check("dn idle valid", 32'(ser_valid1), 32'd0);

        // Reset in the middle of a word.
        load0(8'hFF);
        stream0(8'hFF, 3, 1'b0, 8'h00, -1, 0);
        check("pre-rst sel", 32'(mux_s0), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle0("mid rst", 3'd0);
        check("mid rst mux_i", 32'(mux_i0), 32'h00);
        @(negedge clk);
        check_idle0("mid rst hold", 3'd0);
        load0(8'h3C);
        stream0(8'h3C, NB, 1'b0, 8'h00, -1, 0);
        check_idle0("after 3c", 3'd7);

`ifdef MUX_SCAN_PARITY_EN
        // Odd-weight word: parity beat must be 1.
        load0(8'h07);
        stream0(8'h07, NB, 1'b0, 8'h00, -1, 0);
        check_idle0("after 07", 3'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter: SCAN_DOWN, 0, select order (0: s counts 0->7; 1: s counts 7->0).
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  in  1  upstream word valid.
REQ-005 SHALL have port: in_data  in  8  upstream word.
REQ-006 SHALL have port: in_ready  out  1  block accepts word this cycle.
REQ-007 SHALL have port: mux_i  out  8  held word, drives 8:1 mux data inputs.
REQ-008 SHALL have port: mux_s  out  3  registered select, drives 8:1 mux select.
REQ-009 SHALL have port: mux_y  in  1  8:1 mux output (combinational return).
REQ-010 SHALL have port: ser_valid  out  1  serial beat valid.
REQ-011 SHALL have port: ser_bit  out  1  serial beat data.
REQ-012 SHALL have port: ser_last  out  1  final beat of current word.
REQ-013 SHALL have port: ser_ready  in  1  downstream accepts beat.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT; beat transfer = ser_valid & ser_ready; load = in_valid & in_ready.
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==SHIFT & ser_last & ser_ready), combinationally.
REQ-016 SHALL, on load, register in_data into mux_i, set mux_s to first select (0, or 7 if SCAN_DOWN=1), enter SHIFT next cycle.
REQ-017 SHALL drive ser_valid=1 only in SHIFT; ser_bit = mux_y combinationally during data beats.
REQ-018 SHALL advance mux_s by one (+1, or -1 if SCAN_DOWN=1) per beat transfer; hold mux_s, mux_i, ser_bit stable while ser_valid & !ser_ready.
REQ-019 SHALL assert ser_last on the final beat (mux_s = 7, or 0 if SCAN_DOWN=1, when parity disabled).
REQ-020 SHALL, on last-beat transfer with load in same cycle, reload and stay in SHIFT: zero-bubble back-to-back words.
REQ-021 SHALL, on last-beat transfer without load, return to IDLE; mux_i, mux_s keep last values.
REQ-022 SHALL ignore in_valid in SHIFT except on the last-beat transfer cycle; in_data not sampled otherwise.
REQ-023 SHALL hold latency of 1 cycle from load to first ser_valid; exactly 8 beats per word (9 with parity).

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set state=IDLE, mux_i=8'h00, mux_s=3'd0 (3'd7 if SCAN_DOWN=1), parity register=0, beat counter=0.
REQ-025 SHALL, during/after reset, present ser_valid=0, ser_last=0, in_ready=1 from the first cycle after reset.
REQ-026 SHALL, on reset mid-word, discard the word; no further beats of it emitted.

Configuration
REQ-027 SHALL, with MUX_SCAN_PARITY_EN defined, compute even parity of the loaded word at load and append a 9th beat after the 8 data beats: ser_bit = parity, mux_s held at final select, ser_last on the 9th beat only.
REQ-028 SHALL, without MUX_SCAN_PARITY_EN, emit exactly 8 beats, with no parity logic synthesized.

Verification
REQ-029 SHALL cover: reset, load 8'hA5, ser_ready=1 constantly, SCAN_DOWN=0 -> beats 1,0,1,0,0,1,0,1 on cycles 1-8, ser_last on beat 8, in_ready=1 in cycle 8.
REQ-030 SHALL cover: words 8'h0F then 8'hF0 offered back-to-back, ser_ready=1 -> 16 contiguous beats, no ser_valid gap, ser_last on beats 8 and 16.
REQ-031 SHALL cover: load 8'h81, ser_ready=0 for 5 cycles at beat 3 -> mux_s=2 and ser_bit=0 held stable through the stall, in_ready=0, sequence resumes intact.
REQ-032 SHALL cover: SCAN_DOWN=1, load 8'h01 -> first beat 0 with mux_s=7, last beat 1 with mux_s=0.
REQ-033 SHALL cover: rst=1 at beat 4 of 8'hFF -> next cycle ser_valid=0, in_ready=1, mux_s=0; new word 8'h3C serializes correctly.
REQ-034 SHALL cover: MUX_SCAN_PARITY_EN defined, load 8'h07 -> 9 beats, beat 9 ser_bit=1, ser_last only on beat 9.
